// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: debug run controller for a CPU core.
// Sequences CPU reset, free run with an optional PC breakpoint, and counted single-step.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | CPU clock gated, waiting for a command
// CPURST | cpu_rst asserted, down-counter times RST_CYCLES
// RUN    | CPU enabled until halt, breakpoint or STOP
// STEP   | CPU enabled for a counted number of retirements
module cpu_run_ctrl #(
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  input  logic        cmd_bp_en,
  input  logic        cpu_commit_en,
  input  logic [31:0] cpu_commit_pc,
  input  logic        cpu_commit_halt,
  output logic        cpu_rst,
  output logic        cpu_global_en,
  output logic [1:0]  status_state,
  output logic [1:0]  status_cause,
  output logic [31:0] commit_cnt,
  output logic        done_pulse
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPURST = 2'd1,
    RUN    = 2'd2,
    STEP   = 2'd3
  } state_t;

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_HALT = 2'd1;
  localparam logic [1:0] CAUSE_BP   = 2'd2;
  localparam logic [1:0] CAUSE_STOP = 2'd3;

  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES);

  state_t      state, state_nxt;
  logic [7:0]  rst_cnt, rst_cnt_nxt;
  logic [31:0] remaining, remaining_nxt;
  logic [31:0] bp_pc, bp_pc_nxt;
  logic        bp_en, bp_en_nxt;
  logic [1:0]  cause_nxt;
  logic [31:0] cnt_q, cnt_nxt;

  logic cmd_fire;
  logic stop_req;
  logic commit;
  logic bp_hit;
  logic step_last;
  logic rst_tc;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign stop_req  = cmd_fire & (cmd_op == OP_STOP);
  // Retirements only count while the core is actually clocked.
  assign commit    = cpu_commit_en & cpu_global_en;
  assign bp_hit    = bp_en & (cpu_commit_pc == bp_pc);
  assign step_last = (state == STEP) & (remaining == 32'd1);
  assign rst_tc    = (rst_cnt <= 8'd1);
  assign commit_cnt = cnt_q;

  always_comb begin
    state_nxt     = state;
    rst_cnt_nxt   = rst_cnt;
    remaining_nxt = remaining;
    bp_pc_nxt     = bp_pc;
    bp_en_nxt     = bp_en;
    cause_nxt     = status_cause;
    cnt_nxt       = commit ? cnt_q + 32'd1 : cnt_q;

    unique case (state)
      IDLE: begin
        if (cmd_fire) begin
          case (cmd_op)
            OP_RESET: begin
              state_nxt   = CPURST;
              rst_cnt_nxt = RST_LOAD;
              cnt_nxt     = 32'd0;
              cause_nxt   = CAUSE_NONE;
            end
            OP_RUN: begin
              state_nxt = RUN;
              bp_pc_nxt = cmd_arg;
              bp_en_nxt = cmd_bp_en;
            end
            OP_STEP: begin
              state_nxt     = STEP;
              remaining_nxt = (cmd_arg == 32'd0) ? 32'd1 : cmd_arg;
            end
            default: begin
            end
          endcase
        end
      end

      CPURST: begin
        if (rst_tc) begin
          state_nxt = IDLE;
        end else begin
          rst_cnt_nxt = rst_cnt - 8'd1;
        end
      end

      RUN, STEP: begin
        // A terminating commit decides the cause even when STOP arrives with it.
        if (commit && cpu_commit_halt) begin
          state_nxt = IDLE;
          cause_nxt = CAUSE_HALT;
        end else if (commit && bp_hit) begin
          state_nxt = IDLE;
          cause_nxt = CAUSE_BP;
        end else if (commit && step_last) begin
          state_nxt = IDLE;
          cause_nxt = CAUSE_STOP;
        end else if (stop_req) begin
          state_nxt = IDLE;
          cause_nxt = CAUSE_STOP;
        end else if (commit && (state == STEP)) begin
          remaining_nxt = remaining - 32'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= CPURST;
      rst_cnt       <= RST_LOAD;
      remaining     <= 32'd0;
      bp_pc         <= 32'd0;
      bp_en         <= 1'b0;
      status_cause  <= CAUSE_NONE;
      cnt_q         <= 32'd0;
      done_pulse    <= 1'b0;
      cpu_rst       <= 1'b1;
      cpu_global_en <= 1'b0;
      cmd_ready     <= 1'b0;
      status_state  <= CPURST;
    end else begin
      state         <= state_nxt;
      rst_cnt       <= rst_cnt_nxt;
      remaining     <= remaining_nxt;
      bp_pc         <= bp_pc_nxt;
      bp_en         <= bp_en_nxt;
      status_cause  <= cause_nxt;
      cnt_q         <= cnt_nxt;
      // Outputs are registered from the next state so they line up with it.
      done_pulse    <= (state != IDLE) && (state_nxt == IDLE);
      cpu_rst       <= (state_nxt == CPURST);
      cpu_global_en <= (state_nxt == RUN) || (state_nxt == STEP);
      cmd_ready     <= (state_nxt != CPURST);
      status_state  <= state_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: randomized scoreboard bench for cpu_run_ctrl.
// Stimulus pushes expected stop records; a monitor pops them on done_pulse.
module tb_cpu_run_ctrl;
  localparam int RST_CYCLES = 4;
  localparam logic [31:0] NO_PC = 32'h0000_0001;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic        cmd_bp_en = 1'b0;
  logic        cpu_commit_en = 1'b0;
  logic [31:0] cpu_commit_pc = 32'd0;
  logic        cpu_commit_halt = 1'b0;
  logic        cmd_ready, cpu_rst, cpu_global_en, done_pulse;
  logic [1:0]  status_state, status_cause;
  logic [31:0] commit_cnt;

  cpu_run_ctrl #(.RST_CYCLES(RST_CYCLES)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_arg        (cmd_arg),
    .cmd_bp_en      (cmd_bp_en),
    .cpu_commit_en  (cpu_commit_en),
    .cpu_commit_pc  (cpu_commit_pc),
    .cpu_commit_halt(cpu_commit_halt),
    .cpu_rst        (cpu_rst),
    .cpu_global_en  (cpu_global_en),
    .status_state   (status_state),
    .status_cause   (status_cause),
    .commit_cnt     (commit_cnt),
    .done_pulse     (done_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int kind;

  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [1:0]  cause;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t got;

  // Reference model: architectural state as seen from outside the block.
  logic [31:0] m_cnt   = 32'd0;
  logic [31:0] m_bp    = 32'd0;
  logic        m_bp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge sys_clk) begin
    check("cpu_rst_in_cpurst", 32'(cpu_rst), 32'(status_state == 2'd1));
    check("global_en_in_run_step", 32'(cpu_global_en), 32'(status_state[1]));
    check("cmd_ready_not_cpurst", 32'(cmd_ready), 32'(status_state != 2'd1));
    if (done_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("done_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        got = exp_q.pop_front();
        check("done_cycle", 32'(cyc), 32'(got.cyc));
        check("stop_cause", 32'(status_cause), 32'(got.cause));
        check("stop_commit_cnt", commit_cnt, got.cnt);
        check("idle_at_done", 32'(status_state), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Idle-time inputs: commit wiggles here must be ignored by the DUT.
  task automatic quiet();
    cmd_valid       = 1'b0;
    cmd_op          = 2'd0;
    cmd_arg         = 32'd0;
    cmd_bp_en       = 1'b0;
    cpu_commit_en   = 1'($urandom_range(0, 1));
    cpu_commit_pc   = 32'($urandom_range(0, 15)) << 2;
    cpu_commit_halt = 1'($urandom_range(0, 1));
  endtask

  task automatic release_reset();
    sys_rst = 1'b0;
    exp_q.push_back('{cyc + RST_CYCLES, 2'd0, 32'd0});
    m_cnt   = 32'd0;
    m_bp    = 32'd0;
    m_bp_en = 1'b0;
    repeat (RST_CYCLES + 1) begin
      quiet();
      tick();
    end
  endtask

  task automatic reset_cpu();
    quiet();
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_arg   = $urandom;
    exp_q.push_back('{cyc + 1 + RST_CYCLES, 2'd0, 32'd0});
    m_cnt = 32'd0;
    tick();
    repeat (RST_CYCLES + 1) begin
      quiet();
      tick();
    end
  endtask

  task automatic session(input bit step, input logic [31:0] arg, input bit bp_en_in,
                         input int budget, input int commit_pct, input int stop_pct,
                         input logic [31:0] halt_pc, input int halt_pct, input bit seq_pc);
    logic [31:0] rem;
    logic [31:0] pc;
    logic [1:0]  cause;
    bit          c, h, s, fin;
    int          n;
    quiet();
    cmd_valid = 1'b1;
    cmd_op    = step ? 2'd2 : 2'd1;
    cmd_arg   = arg;
    cmd_bp_en = bp_en_in;
    if (!step) begin
      m_bp    = arg;
      m_bp_en = bp_en_in;
    end
    rem = (arg == 32'd0) ? 32'd1 : arg;
    tick();
    pc = 32'd0;
    fin = 1'b0;
    n = 0;
    cause = 2'd0;
    while (!fin) begin
      if (!seq_pc) pc = 32'($urandom_range(0, 15)) << 2;
      c = ($urandom_range(0, 99) < commit_pct);
      h = (pc == halt_pc) || ($urandom_range(0, 99) < halt_pct);
      s = (n >= budget) || ($urandom_range(0, 99) < stop_pct);
      cpu_commit_en   = c;
      cpu_commit_pc   = pc;
      cpu_commit_halt = h;
      cmd_valid = s || ($urandom_range(0, 9) == 0);
      cmd_op    = s ? 2'd3 : 2'($urandom_range(0, 2));
      cmd_arg   = $urandom;
      cmd_bp_en = 1'($urandom_range(0, 1));
      if (c) begin
        m_cnt = m_cnt + 32'd1;
        fin = 1'b1;
        if (h) cause = 2'd1;
        else if (m_bp_en && pc == m_bp) cause = 2'd2;
        else if (step && rem == 32'd1) cause = 2'd3;
        else if (s) cause = 2'd3;
        else begin
          fin = 1'b0;
          if (step) rem = rem - 32'd1;
        end
      end else if (s) begin
        fin = 1'b1;
        cause = 2'd3;
      end
      if (fin) exp_q.push_back('{cyc + 1, cause, m_cnt});
      tick();
      if (c && seq_pc) pc = pc + 32'd4;
      n++;
    end
    repeat (2) begin
      quiet();
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
    $fatal(1);
  end

  initial begin
    quiet();
    sys_rst = 1'b1;
    repeat (3) tick();
    @(negedge sys_clk);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_global_en", 32'(cpu_global_en), 32'd0);
    check("rst_commit_cnt", commit_cnt, 32'd0);
    check("rst_cause", 32'(status_cause), 32'd0);
    check("rst_done", 32'(done_pulse), 32'd0);
    check("rst_state", 32'(status_state), 32'd1);
    #1;
    release_reset();
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

    session(1'b1, 32'd3, 1'b0, 100, 100, 0, NO_PC, 0, 1'b1);
    check("step3_cnt", commit_cnt, 32'd3);
    check("step3_cause", 32'(status_cause), 32'd3);
    session(1'b1, 32'd0, 1'b0, 100, 100, 0, NO_PC, 0, 1'b1);
    check("step0_cnt", commit_cnt, 32'd4);

    reset_cpu();
    session(1'b0, 32'h1C, 1'b1, 100, 100, 0, NO_PC, 0, 1'b1);
    check("bp_cnt", commit_cnt, 32'd8);
    check("bp_cause", 32'(status_cause), 32'd2);
    session(1'b0, 32'h10, 1'b1, 100, 100, 0, 32'h10, 0, 1'b1);
    check("halt_at_bp_cnt", commit_cnt, 32'd13);
    check("halt_at_bp_cause", 32'(status_cause), 32'd1);
    session(1'b0, 32'h0, 1'b0, 3, 100, 0, NO_PC, 0, 1'b1);
    check("stop_with_commit_cnt", commit_cnt, 32'd17);
    check("stop_with_commit_cause", 32'(status_cause), 32'd3);

    quiet();
    force dut.cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    check("preload_cnt", commit_cnt, 32'hFFFF_FFFF);
    session(1'b1, 32'd1, 1'b0, 100, 100, 0, NO_PC, 0, 1'b1);
    check("wrap_cnt", commit_cnt, 32'd0);
    reset_cpu();
    check("reset_cpu_cnt", commit_cnt, 32'd0);
    check("reset_cpu_cause", 32'(status_cause), 32'd0);

    // sys_rst in the middle of RUN beats a simultaneous STOP and halt commit
    quiet();
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_arg   = NO_PC;
    cmd_bp_en = 1'b1;
    tick();
    repeat (3) begin
      quiet();
      cpu_commit_en   = 1'b1;
      cpu_commit_halt = 1'b0;
      tick();
    end
    sys_rst         = 1'b1;
    cmd_valid       = 1'b1;
    cmd_op          = 2'd3;
    cpu_commit_en   = 1'b1;
    cpu_commit_halt = 1'b1;
    tick();
    @(negedge sys_clk);
    check("midrun_rst_cnt", commit_cnt, 32'd0);
    check("midrun_rst_state", 32'(status_state), 32'd1);
    #1;
    release_reset();

    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        reset_cpu();
      end else if (kind < 5) begin
        session(1'b1, 32'($urandom_range(0, 6)), 1'b0, int'($urandom_range(2, 30)),
                int'($urandom_range(30, 100)), 3, NO_PC, 3, 1'($urandom_range(0, 1)));
      end else begin
        session(1'b0, 32'($urandom_range(0, 15)) << 2, 1'($urandom_range(0, 1)),
                int'($urandom_range(2, 30)), int'($urandom_range(30, 100)), 3, NO_PC, 3,
                1'($urandom_range(0, 1)));
      end
    end

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    check("pending_done", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
